idex_latch: RTL

Decode-to-execute pipeline register of the pipelined RISC core. It captures the decoded operands and ALU controls (Op, invA, invB, Cin, sign) from decode and presents them registered to the execute-stage ALU. It resolves RAW hazards by bypassing EX/MEM and MEM/WB results into the operands at capture. While held, it snoops those buses to refresh the held operands. It also raises a load-use stall request toward the hazard unit.

---
 rtl/core_pkg.sv | 10 +
 rtl/fwd_mux.sv | 20 ++
 rtl/idex_latch.sv | 106 ++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared widths, ALU opcodes and bubble value for the pipelined core
package core_pkg;
   localparam int DATA_W  = 16;
   localparam int RADDR_W = 3;
   localparam logic [2:0] OP_ADD = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_AND = 3'b111;
   localparam logic [2:0] OP_BUBBLE = 3'b000;
endpackage

// File: rtl/fwd_mux.sv
// fwd_mux: picks the youngest in-flight result for a source register, else the given value
module fwd_mux #(
   parameter int DATA_W  = core_pkg::DATA_W,
   parameter int RADDR_W = core_pkg::RADDR_W
) (
   input  logic [RADDR_W-1:0] addr,
   input  logic               used,
   input  logic [DATA_W-1:0]  rf_val,
   input  logic [RADDR_W-1:0] exmem_rd,
   input  logic               exmem_we,
   input  logic [DATA_W-1:0]  exmem_res,
   input  logic [RADDR_W-1:0] memwb_rd,
   input  logic               memwb_we,
   input  logic [DATA_W-1:0]  memwb_res,
   output logic [DATA_W-1:0]  val
);
   assign val = !used                          ? rf_val    :
                (exmem_we && exmem_rd == addr) ? exmem_res :
                (memwb_we && memwb_rd == addr) ? memwb_res : rf_val;
endmodule

// File: rtl/idex_latch.sv
// idex_latch: decode-to-execute pipeline register with operand bypass,
// held-operand refresh during stalls and a load-use stall request
module idex_latch #(
   parameter int DATA_W  = core_pkg::DATA_W,
   parameter int RADDR_W = core_pkg::RADDR_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               id_valid,
   input  logic [DATA_W-1:0]  id_A,
   input  logic [DATA_W-1:0]  id_B,
   input  logic [RADDR_W-1:0] id_rs,
   input  logic [RADDR_W-1:0] id_rt,
   input  logic               id_rs_used,
   input  logic               id_rt_used,
   input  logic [2:0]         id_Op,
   input  logic               id_invA,
   input  logic               id_invB,
   input  logic               id_Cin,
   input  logic               id_sign,
   input  logic [RADDR_W-1:0] id_rd,
   input  logic               id_rd_we,
   input  logic               id_is_load,
   input  logic               stall,
   input  logic               flush,
   input  logic [RADDR_W-1:0] exmem_rd,
   input  logic               exmem_we,
   input  logic [DATA_W-1:0]  exmem_res,
   input  logic [RADDR_W-1:0] memwb_rd,
   input  logic               memwb_we,
   input  logic [DATA_W-1:0]  memwb_res,
   output logic               ex_valid,
   output logic [DATA_W-1:0]  ex_A,
   output logic [DATA_W-1:0]  ex_B,
   output logic [2:0]         ex_Op,
   output logic               ex_invA,
   output logic               ex_invB,
   output logic               ex_Cin,
   output logic               ex_sign,
   output logic [RADDR_W-1:0] ex_rd,
   output logic               ex_rd_we,
   output logic               ex_is_load,
   output logic               stall_req
);
   import core_pkg::*;
   logic [RADDR_W-1:0] ex_rs, ex_rt;
   logic               ex_rs_used, ex_rt_used;
   logic [DATA_W-1:0]  fwd_a, fwd_b;
   // One mux pair serves both capture and held-operand refresh; stall selects the held sources.
   fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_a (
      .addr(stall ? ex_rs : id_rs), .used(stall ? ex_rs_used : id_rs_used),
      .rf_val(stall ? ex_A : id_A),
      .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_res(exmem_res),
      .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_res(memwb_res),
      .val(fwd_a)
   );
   fwd_mux #(.DATA_W(DATA_W), .RADDR_W(RADDR_W)) u_fwd_b (
      .addr(stall ? ex_rt : id_rt), .used(stall ? ex_rt_used : id_rt_used),
      .rf_val(stall ? ex_B : id_B),
      .exmem_rd(exmem_rd), .exmem_we(exmem_we), .exmem_res(exmem_res),
      .memwb_rd(memwb_rd), .memwb_we(memwb_we), .memwb_res(memwb_res),
      .val(fwd_b)
   );
   assign stall_req = ex_valid && ex_is_load && ex_rd_we && id_valid &&
                      ((id_rs_used && id_rs == ex_rd) || (id_rt_used && id_rt == ex_rd));
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         ex_valid   <= 1'b0;
         ex_A       <= '0;
         ex_B       <= '0;
         ex_Op      <= OP_BUBBLE;
         ex_invA    <= 1'b0;
         ex_invB    <= 1'b0;
         ex_Cin     <= 1'b0;
         ex_sign    <= 1'b0;
         ex_rd      <= '0;
         ex_rd_we   <= 1'b0;
         ex_is_load <= 1'b0;
         ex_rs      <= '0;
         ex_rt      <= '0;
         ex_rs_used <= 1'b0;
         ex_rt_used <= 1'b0;
      end else if (stall) begin
         if (ex_valid) begin
            ex_A <= fwd_a;
            ex_B <= fwd_b;
         end
      end else begin
         ex_valid   <= id_valid;
         ex_A       <= fwd_a;
         ex_B       <= fwd_b;
         ex_Op      <= id_Op;
         ex_invA    <= id_invA;
         ex_invB    <= id_invB;
         ex_Cin     <= id_Cin;
         ex_sign    <= id_sign;
         ex_rd      <= id_rd;
         ex_rd_we   <= id_valid && id_rd_we;
         ex_is_load <= id_valid && id_is_load;
         ex_rs      <= id_rs;
         ex_rt      <= id_rt;
         ex_rs_used <= id_rs_used;
         ex_rt_used <= id_rt_used;
      end
   end
endmodule
